// File: rtl/kontroler_przerwan_pkg.sv
// Shared types and vector arithmetic for the kontroler_przerwan interrupt controller.
package kontroler_przerwan_pkg;

    typedef enum logic {
        CFG_MASK = 1'b0,
        CFG_MODE = 1'b1
    } cfg_addr_t;

    localparam int VEC_BASE_DEF = 'h02;
    localparam int VEC_STEP_DEF = 2;

    // Computed at full width; callers truncate to VEC_W, which gives the modulo wrap.
    function automatic logic [31:0] vec_calc(input logic [31:0] base,
                                             input logic [31:0] step,
                                             input logic [31:0] id);
        return base + id * step;
    endfunction

endpackage

// File: rtl/kontroler_przerwan_sync.sv
// Per-source 2-flop synchroniser with rising-edge detect on the synchronised level.
module przerwanie_sync (
    input  logic clk,
    input  logic rst,
    input  logic irq,
    output logic level,
    output logic rise
);

    logic s1, s2, s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= irq;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~s3;

endmodule

// File: rtl/kontroler_przerwan.sv
// Vectored fixed-priority interrupt controller (index 0 highest).
// Define KONTROLER_PRZERWAN_ZAGNIEZDZANIE_EN to build the nested in-service stack.
module kontroler_przerwan
    import kontroler_przerwan_pkg::*;
#(
    parameter int                N_SRC      = 4,
    parameter int                VEC_W      = 8,
    parameter logic [VEC_W-1:0]  VEC_BASE   = VEC_W'(VEC_BASE_DEF),
    parameter int                VEC_STEP   = VEC_STEP_DEF,
    parameter int                NEST_DEPTH = 2,
    localparam int               ID_W       = $clog2(N_SRC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_SRC-1:0]  irq_in,
    input  logic              int_enable,
    input  logic              int_disable,
    input  logic              int_ack,
    input  logic              int_reti,
    input  logic              cfg_wr,
    input  logic              cfg_addr,
    input  logic [N_SRC-1:0]  cfg_data,
    output logic              int_req,
    output logic [VEC_W-1:0]  int_vector,
    output logic [ID_W-1:0]   int_id,
    output logic [N_SRC-1:0]  pending,
    output logic              in_service,
    output logic              reti_err
);

    logic [N_SRC-1:0] level, rise, mask, mode, masked, pending_nxt;
    logic [ID_W-1:0]  sel_id;
    logic             any, blocked, ack_take, enable, enable_nxt, ack_clears_en;

    for (genvar g = 0; g < N_SRC; g++) begin : g_sync
        przerwanie_sync u_sync (
            .clk   (clk),
            .rst   (rst),
            .irq   (irq_in[g]),
            .level (level[g]),
            .rise  (rise[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask <= '0;
            mode <= '0;
        end else if (cfg_wr) begin
            case (cfg_addr_t'(cfg_addr))
                CFG_MASK: mask <= cfg_data;
                CFG_MODE: mode <= cfg_data;
                default:  mask <= mask;
            endcase
        end
    end

    assign masked = pending & mask;
    assign any    = |masked;

    always_comb begin
        sel_id = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (masked[i]) sel_id = ID_W'(i);
        end
    end

    assign int_req    = enable & any & ~blocked;
    assign int_id     = sel_id;
    assign int_vector = VEC_W'(vec_calc(32'(VEC_BASE), 32'(VEC_STEP), 32'(sel_id)));
    assign ack_take   = int_ack & int_req;

    // A rise arriving in the ack cycle re-latches the bit instead of being lost.
    always_comb begin
        pending_nxt = pending;
        for (int i = 0; i < N_SRC; i++) begin
            if (mode[i]) begin
                pending_nxt[i] = pending[i] | rise[i];
                if (ack_take && sel_id == ID_W'(i)) pending_nxt[i] = rise[i];
            end else begin
                pending_nxt[i] = level[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) pending <= '0;
        else     pending <= pending_nxt;
    end

    always_comb begin
        enable_nxt = enable;
        if (ack_take && ack_clears_en) enable_nxt = 1'b0;
        if (int_reti)                  enable_nxt = 1'b1;
        if (int_enable)                enable_nxt = 1'b1;
        if (int_disable)               enable_nxt = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enable   <= 1'b0;
            reti_err <= 1'b0;
        end else begin
            enable <= enable_nxt;
            if (int_reti && !in_service) reti_err <= 1'b1;
        end
    end

`ifdef KONTROLER_PRZERWAN_ZAGNIEZDZANIE_EN
    localparam int CNT_W = $clog2(NEST_DEPTH + 1);

    logic [ID_W-1:0]  stk [NEST_DEPTH];
    logic [CNT_W-1:0] cnt;
    logic             pop;

    assign pop = int_reti && (cnt != '0);

    // stk[0] is the top; push shifts deeper, pop shifts up.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            for (int i = 0; i < NEST_DEPTH; i++) stk[i] <= '0;
        end else if (ack_take && pop) begin
            stk[0] <= sel_id;
        end else if (ack_take) begin
            stk[0] <= sel_id;
            for (int i = 1; i < NEST_DEPTH; i++) stk[i] <= stk[i-1];
            cnt <= cnt + 1'b1;
        end else if (pop) begin
            for (int i = 0; i < NEST_DEPTH - 1; i++) stk[i] <= stk[i+1];
            cnt <= cnt - 1'b1;
        end
    end

    assign in_service    = (cnt != '0);
    assign blocked       = (cnt == CNT_W'(NEST_DEPTH)) || (in_service && sel_id >= stk[0]);
    assign ack_clears_en = 1'b0;
`else
    logic svc_valid;

    always_ff @(posedge clk) begin
        if (rst)           svc_valid <= 1'b0;
        else if (ack_take) svc_valid <= 1'b1;
        else if (int_reti) svc_valid <= 1'b0;
    end

    assign in_service    = svc_valid;
    assign blocked       = svc_valid;
    assign ack_clears_en = 1'b1;
`endif

endmodule

// File: tb/tb_kontroler_przerwan.sv
// Scoreboard bench for kontroler_przerwan: stimulus queues expectations, a negedge monitor checks them.
module tb_kontroler_przerwan;
    import kontroler_przerwan_pkg::*;

    localparam int S_REQ = 0, S_PEND = 1, S_ERR = 2, S_SVC = 3, S_ID = 4, S_VEC = 5;

    logic       clk = 1'b0, rst = 1'b1;
    logic [3:0] irq_in = '0, cfg_data = '0;
    logic       int_enable = 0, int_disable = 0, int_ack = 0, int_reti = 0;
    logic       cfg_wr = 0, cfg_addr = 0;
    logic       int_req, in_service, reti_err;
    logic [7:0] int_vector;
    logic [1:0] int_id;
    logic [3:0] pending;

    kontroler_przerwan #(.N_SRC(4), .VEC_W(8)) dut (
        .clk(clk), .rst(rst), .irq_in(irq_in),
        .int_enable(int_enable), .int_disable(int_disable),
        .int_ack(int_ack), .int_reti(int_reti),
        .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .int_req(int_req), .int_vector(int_vector), .int_id(int_id),
        .pending(pending), .in_service(in_service), .reti_err(reti_err)
    );

    always #5 clk = ~clk;

    typedef struct { int id; int vec; } grant_t;
    typedef struct { string name; int sig; int exp; } stat_t;
    grant_t grant_q[$];
    stat_t  stat_q[$];

    int n_checks = 0, n_fail = 0, cycles = 0;
    bit done = 0, req_q = 0;

    function automatic int sample(int sig);
        case (sig)
            S_REQ:   return int'(int_req);
            S_PEND:  return int'(pending);
            S_ERR:   return int'(reti_err);
            S_SVC:   return int'(in_service);
            S_ID:    return int'(int_id);
            default: return int'(int_vector);
        endcase
    endfunction

    always @(negedge clk) begin
        stat_t  s;
        grant_t g;
        int     act;
        cycles++;
        while (stat_q.size() > 0) begin
            s   = stat_q.pop_front();
            act = sample(s.sig);
            n_checks++;
            if (act != s.exp) begin
                n_fail++;
                $display("FAIL %s: actual %0h required %0h", s.name, act, s.exp);
            end
        end
        if (int_req && !req_q) begin
            n_checks++;
            if (grant_q.size() == 0) begin
                n_fail++;
                $display("FAIL grant_unexpected: actual id %0d vec %0h required no request", int_id, int_vector);
            end else begin
                g = grant_q.pop_front();
                if (int_id != g.id || int_vector != g.vec) begin
                    n_fail++;
                    $display("FAIL grant: actual id %0d vec %0h required id %0d vec %0h",
                             int_id, int_vector, g.id, g.vec);
                end
            end
        end
        req_q <= int_req;
        if (done) begin
            n_checks++;
            if (grant_q.size() != 0) begin
                n_fail++;
                $display("FAIL grant_missing: actual %0d grants outstanding required 0", grant_q.size());
            end
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end else if (cycles > 5000) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: actual %0d cycles required under 5000", cycles);
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_stat(string name, int sig, int v);
        stat_q.push_back('{name, sig, v});
    endtask

    task automatic exp_grant(int id, int vec);
        grant_q.push_back('{id, vec});
    endtask

    task automatic cfg(logic addr, logic [3:0] data);
        cfg_wr = 1; cfg_addr = addr; cfg_data = data;
        step();
        cfg_wr = 0;
    endtask

    // Single-cycle pulse; returns right after the edge that sets pending.
    task automatic pulse(logic [3:0] bits);
        irq_in = bits;
        step();
        irq_in = '0;
        step(2);
    endtask

    task automatic ack();
        int_ack = 1; step(); int_ack = 0;
    endtask

    task automatic reti();
        int_reti = 1; step(); int_reti = 0;
    endtask

    initial begin
        step(2);
        exp_stat("rst_req", S_REQ, 0);
        exp_stat("rst_vec", S_VEC, 'h02);
        exp_stat("rst_id", S_ID, 0);
        exp_stat("rst_pend", S_PEND, 0);
        exp_stat("rst_svc", S_SVC, 0);
        exp_stat("rst_err", S_ERR, 0);
        rst = 0;
        step();

        // 1: edge on src1, three-edge latency
        cfg(CFG_MASK, 4'b0011);
        cfg(CFG_MODE, 4'b0011);
        int_enable = 1; step(); int_enable = 0;
        irq_in[1] = 1; step(); irq_in[1] = 0;
        exp_stat("t1_req_edge1", S_REQ, 0);
        step();
        exp_stat("t1_req_edge2", S_REQ, 0);
        exp_grant(1, 'h04);
        step();
        exp_stat("t1_req_edge3", S_REQ, 1);
        exp_stat("t1_pend", S_PEND, 'b0010);
        ack();
        exp_stat("t1_ack_req", S_REQ, 0);
        exp_stat("t1_ack_svc", S_SVC, 1);
        exp_stat("t1_ack_pend", S_PEND, 0);
        reti();
        exp_stat("t1_reti_svc", S_SVC, 0);
        exp_stat("t1_reti_err", S_ERR, 0);

        // 2: simultaneous src0/src1, priority then re-request after reti
        exp_grant(0, 'h02);
        pulse(4'b0011);
        exp_stat("t2_pend", S_PEND, 'b0011);
        exp_grant(1, 'h04);
        ack();
        exp_stat("t2_ack_req", S_REQ, 0);
        exp_stat("t2_ack_pend", S_PEND, 'b0010);
        reti();
        exp_stat("t2_rereq", S_REQ, 1);
        exp_stat("t2_vec", S_VEC, 'h04);
        ack();
        reti();
        exp_stat("t2_pend_clr", S_PEND, 0);

        // 3: level src2 reasserts after reti; deassert before ack
        cfg(CFG_MASK, 4'b0111);
        exp_grant(2, 'h06);
        irq_in[2] = 1;
        step(3);
        exp_stat("t3_id", S_ID, 2);
        ack();
        exp_stat("t3_ack_req", S_REQ, 0);
        exp_stat("t3_ack_pend", S_PEND, 'b0100);
        exp_grant(2, 'h06);
        reti();
        exp_stat("t3_rereq", S_REQ, 1);
        irq_in[2] = 0;
        step(3);
        exp_stat("t3_drop_req", S_REQ, 0);
        ack();
        exp_stat("t3_late_ack_svc", S_SVC, 0);

        // 4: masked edge stays latched, unmask raises request
        cfg(CFG_MASK, 4'b0000);
        pulse(4'b0001);
        exp_stat("t4_masked_req", S_REQ, 0);
        exp_stat("t4_masked_pend", S_PEND, 'b0001);
        exp_grant(0, 'h02);
        cfg(CFG_MASK, 4'b0001);
        exp_stat("t4_unmask_req", S_REQ, 1);
        ack();
        reti();
        exp_stat("t4_pend_clr", S_PEND, 0);

        // 5: spurious reti, enable/disable collision, reset mid-handler
        reti();
        exp_stat("t5_err_set", S_ERR, 1);
        step(2);
        exp_stat("t5_err_sticky", S_ERR, 1);
        int_enable = 1; int_disable = 1; step(); int_enable = 0; int_disable = 0;
        cfg(CFG_MASK, 4'b0011);
        pulse(4'b0010);
        exp_stat("t5_dis_wins_req", S_REQ, 0);
        exp_stat("t5_dis_wins_pend", S_PEND, 'b0010);
        exp_grant(1, 'h04);
        int_enable = 1; step(); int_enable = 0;
        exp_stat("t5_en_req", S_REQ, 1);
        ack();
        exp_stat("t5_svc", S_SVC, 1);
        rst = 1;
        step();
        exp_stat("t5_rst_svc", S_SVC, 0);
        exp_stat("t5_rst_err", S_ERR, 0);
        exp_stat("t5_rst_req", S_REQ, 0);
        rst = 0;
        step();

`ifdef KONTROLER_PRZERWAN_ZAGNIEZDZANIE_EN
        // 6: nesting - preemption by higher priority, lower priority held off
        cfg(CFG_MASK, 4'b1111);
        cfg(CFG_MODE, 4'b1111);
        int_enable = 1; step(); int_enable = 0;
        exp_grant(2, 'h06);
        pulse(4'b0100);
        ack();
        exp_stat("t6_svc", S_SVC, 1);
        pulse(4'b1000);
        exp_stat("t6_low_blocked", S_REQ, 0);
        exp_grant(0, 'h02);
        pulse(4'b0001);
        exp_stat("t6_preempt_id", S_ID, 0);
        ack();
        exp_stat("t6_full_req", S_REQ, 0);
        reti();
        exp_stat("t6_pop1_req", S_REQ, 0);
        exp_grant(3, 'h08);
        reti();
        exp_stat("t6_pop2_req", S_REQ, 1);
        ack();
        reti();
`endif

        step(2);
        done = 1;
    end

endmodule
